mac_operand_feeder: RTL and testbench

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

---
 rtl/mac_operand_feeder_pkg.sv | 20 ++
 rtl/mac_operand_feeder_tile_buf.sv | 44 ++++
 rtl/mac_operand_feeder.sv | 150 +++++++++++++++
 tb/tb_mac_operand_feeder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_operand_feeder_pkg.sv
// Shared types for the MAC operand feeder: FP8 element layout, FSM states, default tile size.
package mac_operand_feeder_pkg;

   localparam int FEEDER_N_DEFAULT = 4;

   typedef struct packed {
      logic       sign;
      logic [2:0] exp;
      logic [3:0] mant;
   } fp8_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FULL,
      ST_CLEAR,
      ST_STREAM,
      ST_DONE
   } feeder_state_e;

endpackage

// File: rtl/mac_operand_feeder_tile_buf.sv
// N x N FP8 tile register file with a diagonally skewed read port.
// ROW_SKEW=1: lane e = M[e][t-e] (A feed); ROW_SKEW=0: lane e = M[t-e][e] (B feed).
module feeder_tile_buf
   import mac_operand_feeder_pkg::*;
#(
   parameter int N        = FEEDER_N_DEFAULT,
   parameter bit ROW_SKEW = 1'b1,
   localparam int IW      = (N > 1) ? $clog2(N) : 1,
   localparam int TW      = $clog2(3*N-2)
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [IW-1:0]   wr_row,
   input  logic [IW-1:0]   wr_col,
   input  fp8_t            wr_data,
   input  logic [TW-1:0]   t,
   output logic [N*8-1:0]  rd_data
);

   // No reset: contents are only observed after a full tile has been written.
   fp8_t mem [N][N];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_row][wr_col] <= wr_data;
   end

   for (genvar e = 0; e < N; e++) begin : g_lane
      int         d;
      logic [7:0] lane;

      assign d = int'(t) - e;

      always_comb begin
         lane = 8'h00;
         if (d >= 0 && d < N) begin
            if (ROW_SKEW) lane = mem[e][d[IW-1:0]];
            else          lane = mem[d[IW-1:0]][e];
         end
      end

      assign rd_data[8*e +: 8] = lane;
   end

endmodule

// File: rtl/mac_operand_feeder.sv
// Loads an N x N FP8 tile pair (A, B) beat by beat, then streams skewed operands into a systolic array.
// Optional FEEDER_ABORT_EN adds an abort input that cancels a loaded or streaming tile.
module mac_operand_feeder
   import mac_operand_feeder_pkg::*;
#(
   parameter int N = FEEDER_N_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic [7:0]     load_a,
   input  logic [7:0]     load_b,
   input  logic           go,
`ifdef FEEDER_ABORT_EN
   input  logic           abort,
`endif
   output logic [N*8-1:0] a_row,
   output logic [N*8-1:0] b_col,
   output logic           mac_clear,
   output logic           busy,
   output logic           done
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(3*N-2);
   localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
   localparam logic [TW-1:0] T_LAST   = TW'(3*N-3);

   feeder_state_e   state, state_nxt;
   logic [IW-1:0]   row, row_nxt, col, col_nxt;
   logic [TW-1:0]   t, t_nxt;
   logic            accept, abort_hit;
   logic [N*8-1:0]  a_rd, b_rd, a_nxt, b_nxt;
   logic            ready_nxt, clear_nxt, busy_nxt, done_nxt;

`ifdef FEEDER_ABORT_EN
   assign abort_hit = abort && (state == ST_FULL || state == ST_CLEAR || state == ST_STREAM);
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         row        <= '0;
         col        <= '0;
         t          <= '0;
         load_ready <= 1'b1;
         a_row      <= '0;
         b_col      <= '0;
         mac_clear  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         row        <= row_nxt;
         col        <= col_nxt;
         t          <= t_nxt;
         load_ready <= ready_nxt;
         a_row      <= a_nxt;
         b_col      <= b_nxt;
         mac_clear  <= clear_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      col_nxt   = col;
      t_nxt     = t;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_valid) begin
               accept = 1'b1;
               if (col == LAST_IDX) begin
                  col_nxt = '0;
                  if (row == LAST_IDX) begin
                     row_nxt   = '0;
                     state_nxt = ST_FULL;
                  end else begin
                     row_nxt = row + 1'b1;
                  end
               end else begin
                  col_nxt = col + 1'b1;
               end
            end
         end
         ST_FULL:  if (go) state_nxt = ST_CLEAR;
         ST_CLEAR: begin
            state_nxt = ST_STREAM;
            t_nxt     = '0;
         end
         ST_STREAM: begin
            if (t == T_LAST) begin
               state_nxt = ST_DONE;
               t_nxt     = '0;
            end else begin
               t_nxt = t + 1'b1;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort_hit) begin
         state_nxt = ST_IDLE;
         row_nxt   = '0;
         col_nxt   = '0;
         t_nxt     = '0;
      end
   end

   // Outputs are registered from the next state so operands line up with t in the STREAM cycle itself.
   always_comb begin
      a_nxt     = '0;
      b_nxt     = '0;
      if (state_nxt == ST_STREAM) begin
         a_nxt = a_rd;
         b_nxt = b_rd;
      end
      ready_nxt = (state_nxt == ST_IDLE);
      clear_nxt = (state_nxt == ST_CLEAR);
      busy_nxt  = (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM);
      done_nxt  = (state_nxt == ST_DONE);
   end

   feeder_tile_buf #(.N(N), .ROW_SKEW(1'b1)) u_buf_a (
      .clk     (clk),
      .wr_en   (accept),
      .wr_row  (row),
      .wr_col  (col),
      .wr_data (fp8_t'(load_a)),
      .t       (t_nxt),
      .rd_data (a_rd)
   );

   feeder_tile_buf #(.N(N), .ROW_SKEW(1'b0)) u_buf_b (
      .clk     (clk),
      .wr_en   (accept),
      .wr_row  (row),
      .wr_col  (col),
      .wr_data (fp8_t'(load_b)),
      .t       (t_nxt),
      .rd_data (b_rd)
   );

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder (N=4) with a behavioural 4x4 FP8 systolic array as the consumer.
module tb_mac_operand_feeder;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n, load_valid, load_ready, go, mac_clear, busy, done;
   logic [7:0]     load_a, load_b;
   logic [N*8-1:0] a_row, b_col;
`ifdef FEEDER_ABORT_EN
   logic           abort;
`endif

   mac_operand_feeder #(.N(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_a     (load_a),
      .load_b     (load_b),
      .go         (go),
`ifdef FEEDER_ABORT_EN
      .abort      (abort),
`endif
      .a_row      (a_row),
      .b_col      (b_col),
      .mac_clear  (mac_clear),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N*8-1:0] a;
      logic [N*8-1:0] b;
   } vec_t;
   vec_t tbl [3*N-2];

   logic [7:0] ta [N][N];
   logic [7:0] tb [N][N];

   // Behavioural systolic array: a flows right, b flows down, one register per PE.
   logic [7:0] pa [N][N];
   logic [7:0] pb [N][N];
   real        acc [N][N];

   function automatic real dec(input logic [7:0] v);
      real m;
      int  e;
      e = int'(v[6:4]);
      if (e == 0) m = (real'(int'(v[3:0])) / 16.0) * 0.25;
      else        m = (1.0 + real'(int'(v[3:0])) / 16.0) * (2.0 ** (e - 3));
      return v[7] ? -m : m;
   endfunction

   initial begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            pa[i][j] = 8'h00; pb[i][j] = 8'h00; acc[i][j] = 0.0;
         end
   end

   always @(negedge clk) begin
      logic [7:0] ai, bi;
      logic [7:0] na [N][N];
      logic [7:0] nb [N][N];
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            if (j == 0) ai = a_row[8*i +: 8]; else ai = pa[i][j-1];
            if (i == 0) bi = b_col[8*j +: 8]; else bi = pb[i-1][j];
            na[i][j] = ai;
            nb[i][j] = bi;
            if (mac_clear) acc[i][j] = 0.0;
            else           acc[i][j] = acc[i][j] + dec(ai) * dec(bi);
         end
      pa = na;
      pb = nb;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_beats(input int first, input int count);
      for (int k = first; k < first + count; k++) begin
         load_valid = 1'b1;
         load_a     = ta[k / N][k % N];
         load_b     = tb[k / N][k % N];
         cyc();
      end
      load_valid = 1'b0;
   endtask

   task automatic set_tile1();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ta[i][j] = 8'h10 + 8'(4*i + j);
            tb[i][j] = (i == j) ? 8'h30 : 8'h00;
         end
   endtask

   task automatic set_tile2();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ta[i][j] = 8'h20 + 8'(3*i + j);
            tb[i][j] = 8'h28 + 8'(2*j + i) + ((((i + j) % 3) == 0) ? 8'h80 : 8'h00);
         end
   endtask

   task automatic check_acc(input string tag);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            real r;
            r = 0.0;
            for (int k = 0; k < N; k++) r = r + dec(ta[i][k]) * dec(tb[k][j]);
            chk($sformatf("%s_c%0d%0d", tag, i, j),
                64'($rtoi(acc[i][j] * 4096.0)), 64'($rtoi(r * 4096.0)));
         end
   endtask

   // go from FULL, expect one clear cycle, done 12 cycles after go, then compare the PE tile.
   task automatic run_tile(input string tag);
      int n;
      go = 1'b1;
      cyc();
      go = 1'b0;
      chk({tag, "_clear"}, {mac_clear, busy, done}, 3'b110);
      n = 0;
      while (!done && n < 30) begin
         cyc();
         n++;
      end
      chk({tag, "_done_latency"}, n, 11);
      if (done) check_acc(tag);
      cyc();
   endtask

   initial begin
      int seen;
      tbl[0] = '{32'h00000010, 32'h00000030};
      tbl[1] = '{32'h00001411, 32'h00000000};
      tbl[2] = '{32'h00181512, 32'h00003000};
      tbl[3] = '{32'h1C191613, 32'h00000000};
      tbl[4] = '{32'h1D1A1700, 32'h00300000};
      tbl[5] = '{32'h1E1B0000, 32'h00000000};
      tbl[6] = '{32'h1F000000, 32'h30000000};
      tbl[7] = '{32'h00000000, 32'h00000000};
      tbl[8] = '{32'h00000000, 32'h00000000};
      tbl[9] = '{32'h00000000, 32'h00000000};

      reset_n = 1'b0; load_valid = 1'b0; load_a = 8'h00; load_b = 8'h00; go = 1'b0;
`ifdef FEEDER_ABORT_EN
      abort = 1'b0;
`endif
      cyc();
      cyc();
      chk("reset_ctrl", {load_ready, mac_clear, busy, done}, 4'b1000);
      chk("reset_a_row", a_row, '0);
      chk("reset_b_col", b_col, '0);
      reset_n = 1'b1;

      // Load with a stray go after 5 beats
      set_tile1();
      load_beats(0, 5);
      go = 1'b1;
      cyc();
      go = 1'b0;
      chk("go_in_idle_ignored", {load_ready, busy, mac_clear}, 3'b100);
      load_beats(5, 10);
      chk("ready_before_last", load_ready, 1'b1);
      load_beats(15, 1);
      chk("ready_after_16", load_ready, 1'b0);
      cyc();
      chk("full_holds", {load_ready, busy, done}, 3'b000);

      // Stream tile 1 while junk beats are offered
      load_valid = 1'b1; load_a = 8'hEE; load_b = 8'hEE;
      go = 1'b1;
      cyc();
      go = 1'b0;
      chk("clear_ctrl", {mac_clear, busy, done, load_ready}, 4'b1100);
      chk("clear_ops", {a_row, b_col}, '0);
      for (int s = 0; s < 3*N-2; s++) begin
         cyc();
         chk($sformatf("stream_a_t%0d", s), a_row, tbl[s].a);
         chk($sformatf("stream_b_t%0d", s), b_col, tbl[s].b);
         chk($sformatf("stream_ctrl_t%0d", s), {busy, mac_clear, done, load_ready}, 4'b1000);
      end
      cyc();
      chk("done_ctrl", {done, busy, load_ready}, 3'b100);
      chk("done_ops", {a_row, b_col}, '0);
      check_acc("tile1");
      cyc();
      chk("idle_after_done", {done, load_ready}, 2'b01);

      // Tile 2 beat 0 goes in now; a shifted k would corrupt the product
      set_tile2();
      load_beats(0, 16);
      chk("t2_full", load_ready, 1'b0);
      run_tile("tile2");

      // Reset at stream cycle t=4
      set_tile1();
      load_beats(0, 16);
      go = 1'b1;
      cyc();
      go = 1'b0;
      for (int s = 0; s < 5; s++) cyc();
      chk("rst_pre_t4_a", a_row, 32'h1D1A1700);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      chk("rst_mid_ctrl", {load_ready, busy, mac_clear, done}, 4'b1000);
      chk("rst_mid_ops", {a_row, b_col}, '0);
      seen = 0;
      for (int s = 0; s < 12; s++) begin
         cyc();
         if (done) seen++;
      end
      chk("rst_no_done", seen, 0);
      set_tile2();
      load_beats(0, 16);
      run_tile("post_rst");

`ifdef FEEDER_ABORT_EN
      // Abort at t=2, asserted together with a go that must not matter
      set_tile1();
      load_beats(0, 16);
      go = 1'b1;
      cyc();
      go = 1'b0;
      for (int s = 0; s < 3; s++) cyc();
      chk("abort_pre_t2_a", a_row, 32'h00181512);
      abort = 1'b1;
      go = 1'b1;
      cyc();
      abort = 1'b0;
      go = 1'b0;
      chk("abort_ctrl", {load_ready, busy, mac_clear, done}, 4'b1000);
      chk("abort_ops", {a_row, b_col}, '0);
      seen = 0;
      for (int s = 0; s < 12; s++) begin
         cyc();
         if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      set_tile2();
      load_beats(0, 16);
      run_tile("post_abort");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
